hept_stage_sequencer: RTL and testbench

- Block-level controller that sequences the HEPT kernel stages (transpose_qk, pairwise_dist_sq_rbf, mask_and_normalize, ...) through a batch.
- Each stage is an ap_ctrl_hs sub-function. The sequencer drives its start and consumes its ready/done.
- The sequencer exposes an ap_ctrl_hs interface upward to the kernel top.
- Adds a per-stage watchdog and a run cycle counter for the same status profiling the simulation monitors collect.

---
 rtl/hept_ctrl_pkg.sv | 21 ++
 rtl/hept_stage_sequencer_if.sv | 37 +++
 rtl/hept_stage_watchdog.sv | 40 ++++
 rtl/hept_stage_sequencer.sv | 169 ++++++++++++++++
 tb/tb_hept_stage_sequencer.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hept_ctrl_pkg.sv
// Shared definitions for the HEPT stage sequencer: state encoding, index
// width helper and default sizing.
package hept_ctrl_pkg;

    localparam int HEPT_NUM_STAGES = 3;
    localparam int HEPT_BATCH_SIZE = 4;

    typedef enum logic [2:0] {
        SEQ_IDLE  = 3'd0,
        SEQ_START = 3'd1,
        SEQ_WAIT  = 3'd2,
        SEQ_NEXT  = 3'd3,
        SEQ_DONE  = 3'd4
    } seq_state_e;

    // Index width for a counter over n items; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/hept_stage_sequencer_if.sv
// Control/status bundle between the sequencer, the kernel top (ap_ctrl_hs)
// and the sequenced stage sub-functions.
interface hept_stage_sequencer_if
    import hept_ctrl_pkg::*;
#(
    parameter int NUM_STAGES = HEPT_NUM_STAGES,
    parameter int BATCH_SIZE = HEPT_BATCH_SIZE,
    parameter int CNT_W      = 32
) ();

    logic                                 ap_start;
    logic                                 ap_done;
    logic                                 ap_ready;
    logic                                 ap_idle;
    logic [NUM_STAGES-1:0]                stage_start;
    logic [NUM_STAGES-1:0]                stage_ready;
    logic [NUM_STAGES-1:0]                stage_done;
    logic [idx_width(NUM_STAGES)-1:0]     stage_idx;
    logic [idx_width(BATCH_SIZE)-1:0]     batch_idx;
    logic                                 err_timeout;
    logic [CNT_W-1:0]                     cycle_count;

    // Sequencer side.
    modport slave (
        input  ap_start, stage_ready, stage_done,
        output ap_done, ap_ready, ap_idle, stage_start,
               stage_idx, batch_idx, err_timeout, cycle_count
    );

    // Kernel top plus stage side.
    modport master (
        output ap_start, stage_ready, stage_done,
        input  ap_done, ap_ready, ap_idle, stage_start,
               stage_idx, batch_idx, err_timeout, cycle_count
    );

endinterface

// File: rtl/hept_stage_watchdog.sv
// Per-stage watchdog: counts enabled cycles and flags expiry on the cycle
// the count sits at TIMEOUT-1 while still enabled.
module hept_stage_watchdog #(
    parameter int TIMEOUT = 4096
) (
    input  logic ap_clk,
    input  logic ap_rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int              CW   = $clog2(TIMEOUT);
    localparam logic [CW-1:0]   LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Next count: clear wins over enable; parks at LAST so it cannot wrap.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en && (count_q != LAST)) begin
            count_d = count_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expire = en && (count_q == LAST);

endmodule

// File: rtl/hept_stage_sequencer.sv
// Sequences the HEPT kernel stages over a batch, one ap_ctrl_hs start per
// stage per item, with a per-stage watchdog and a run cycle counter.
//
// state | meaning
// IDLE  | waiting for ap_start, ap_idle high, counters hold last run
// START | stage_start[stage_idx] high until the stage returns ap_ready
// WAIT  | stage accepted start, waiting for its ap_done
// NEXT  | advance stage_idx / batch_idx (one cycle)
// DONE  | ap_done/ap_ready pulse (one cycle), then IDLE
module hept_stage_sequencer
    import hept_ctrl_pkg::*;
#(
    parameter int NUM_STAGES = HEPT_NUM_STAGES,
    parameter int BATCH_SIZE = HEPT_BATCH_SIZE,
    parameter int TIMEOUT    = 4096,
    parameter int CNT_W      = 32
) (
    input  logic                    ap_clk,
    input  logic                    ap_rst_n,
    hept_stage_sequencer_if.slave   bus
);

    localparam int SW = idx_width(NUM_STAGES);
    localparam int BW = idx_width(BATCH_SIZE);

    localparam logic [SW-1:0] LAST_STAGE = SW'(NUM_STAGES - 1);
    localparam logic [BW-1:0] LAST_BATCH = BW'(BATCH_SIZE - 1);

    localparam logic [2:0] ST_IDLE  = SEQ_IDLE;
    localparam logic [2:0] ST_START = SEQ_START;
    localparam logic [2:0] ST_WAIT  = SEQ_WAIT;
    localparam logic [2:0] ST_NEXT  = SEQ_NEXT;
    localparam logic [2:0] ST_DONE  = SEQ_DONE;

    logic [2:0]         state_q,     state_d;
    logic [SW-1:0]      stage_idx_q, stage_idx_d;
    logic [BW-1:0]      batch_idx_q, batch_idx_d;
    logic               err_q,       err_d;
    logic [CNT_W-1:0]   cyc_q,       cyc_d;

    logic               cur_ready;
    logic               cur_done;
    logic               wd_clr;
    logic               wd_en;
    logic               wd_expire;
    logic [NUM_STAGES-1:0] start_vec;

    // Only the handshake of the stage currently being sequenced matters.
    assign cur_ready = bus.stage_ready[stage_idx_q];
    assign cur_done  = bus.stage_done[stage_idx_q];

    assign wd_en  = (state_q == ST_START) || (state_q == ST_WAIT);
    assign wd_clr = (state_q == ST_IDLE) || (state_d == ST_NEXT);

    hept_stage_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .ap_clk   (ap_clk),
        .ap_rst_n (ap_rst_n),
        .clr      (wd_clr),
        .en       (wd_en),
        .expire   (wd_expire)
    );

    // Sequencing FSM; a stage completion on the expiry cycle beats the abort,
    // and an abort leaves both indices frozen for debug.
    always_comb begin
        state_d     = state_q;
        stage_idx_d = stage_idx_q;
        batch_idx_d = batch_idx_q;
        err_d       = err_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.ap_start) begin
                    state_d     = ST_START;
                    stage_idx_d = '0;
                    batch_idx_d = '0;
                    err_d       = 1'b0;
                end
            end
            ST_START: begin
                if (cur_ready && cur_done) begin
                    state_d = ST_NEXT;
                end else if (wd_expire) begin
                    state_d = ST_DONE;
                    err_d   = 1'b1;
                end else if (cur_ready) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cur_done) begin
                    state_d = ST_NEXT;
                end else if (wd_expire) begin
                    state_d = ST_DONE;
                    err_d   = 1'b1;
                end
            end
            ST_NEXT: begin
                if (stage_idx_q != LAST_STAGE) begin
                    stage_idx_d = stage_idx_q + 1'b1;
                    state_d     = ST_START;
                end else begin
                    stage_idx_d = '0;
                    if (batch_idx_q != LAST_BATCH) begin
                        batch_idx_d = batch_idx_q + 1'b1;
                        state_d     = ST_START;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Run cycle counter: cleared on an accepted start, saturating count of
    // every non-IDLE cycle, held through IDLE for readout.
    always_comb begin
        cyc_d = cyc_q;
        if (state_q == ST_IDLE) begin
            if (bus.ap_start) begin
                cyc_d = '0;
            end
        end else if (!(&cyc_q)) begin
            cyc_d = cyc_q + 1'b1;
        end
    end

    // One-hot start to the current stage, decoded from registered state.
    always_comb begin
        start_vec = '0;
        if (state_q == ST_START) begin
            start_vec[stage_idx_q] = 1'b1;
        end
    end

    // State, index, error and counter registers.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q     <= ST_IDLE;
            stage_idx_q <= '0;
            batch_idx_q <= '0;
            err_q       <= 1'b0;
            cyc_q       <= '0;
        end else begin
            state_q     <= state_d;
            stage_idx_q <= stage_idx_d;
            batch_idx_q <= batch_idx_d;
            err_q       <= err_d;
            cyc_q       <= cyc_d;
        end
    end

    assign bus.ap_idle     = (state_q == ST_IDLE);
    assign bus.ap_done     = (state_q == ST_DONE);
    assign bus.ap_ready    = (state_q == ST_DONE);
    assign bus.stage_start = start_vec;
    assign bus.stage_idx   = stage_idx_q;
    assign bus.batch_idx   = batch_idx_q;
    assign bus.err_timeout = err_q;
    assign bus.cycle_count = cyc_q;

endmodule

// File: tb/tb_hept_stage_sequencer.sv
// Directed bench for hept_stage_sequencer: scripted stage stubs answer the
// one-hot starts; expectations are hand-computed cycle counts and start logs.
module tb_hept_stage_sequencer;

    logic ap_clk;
    logic ap_rst_n;

    hept_stage_sequencer_if #(.NUM_STAGES(3), .BATCH_SIZE(4), .CNT_W(32)) bus ();

    hept_stage_sequencer #(
        .NUM_STAGES (3),
        .BATCH_SIZE (4),
        .TIMEOUT    (16),
        .CNT_W      (32)
    ) dut (
        .ap_clk   (ap_clk),
        .ap_rst_n (ap_rst_n),
        .bus      (bus)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Stage stub script: per-stage start cycle of ready / done (0 = never),
    // with one (stage, batch) override and an optional spurious done[0].
    int nom_len [3] = '{5, 7, 3};
    int ready_at[3];
    int done_at [3];
    bit sp_en;
    int sp_s, sp_b, sp_r, sp_d;
    bit spur_en;

    int cnt;
    bit busy;
    int ra, da;
    bit rdy, dn;

    always_comb begin
        ra = ready_at[bus.stage_idx];
        da = done_at[bus.stage_idx];
        if (sp_en && int'(bus.stage_idx) == sp_s && int'(bus.batch_idx) == sp_b) begin
            ra = sp_r;
            da = sp_d;
        end
        rdy = (ra != 0) && bus.stage_start[bus.stage_idx] && (cnt == ra - 1);
        dn  = (da != 0) && (bus.stage_start[bus.stage_idx] || busy) && (cnt == da - 1);
        bus.stage_ready = '0;
        bus.stage_done  = '0;
        bus.stage_ready[bus.stage_idx] = rdy;
        bus.stage_done[bus.stage_idx]  = dn;
        if (spur_en && bus.stage_idx == 2'd1 && bus.stage_start == 3'b000 && busy)
            bus.stage_done[0] = 1'b1;
    end

    always @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            cnt  <= 0;
            busy <= 1'b0;
        end else if (bus.ap_done || dn) begin
            cnt  <= 0;
            busy <= 1'b0;
        end else if ((bus.stage_start != 3'b000) || busy) begin
            cnt  <= cnt + 1;
            busy <= 1'b1;
        end
    end

    // Monitor: log each stage_start burst as batch*1000 + stage*100 + length,
    // count done pulses and ready/done disagreements.
    int log_q[$];
    int exp_q[$];
    int run_len = 0;
    int run_tag = 0;
    int done_cnt = 0;
    int rdy_mis = 0;

    always @(negedge ap_clk) begin
        if (!ap_rst_n) begin
            run_len = 0;
        end else begin
            if (bus.ap_done === 1'b1) done_cnt++;
            if (bus.ap_ready !== bus.ap_done) rdy_mis++;
            if (bus.stage_start != 3'b000) begin
                if (run_len == 0) begin
                    run_tag = int'(bus.batch_idx) * 1000;
                    for (int k = 0; k < 3; k++)
                        if (bus.stage_start[k]) run_tag += k * 100;
                end
                run_len++;
            end else if (run_len != 0) begin
                log_q.push_back(run_tag + run_len);
                run_len = 0;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_nominal();
        for (int s = 0; s < 3; s++) begin
            ready_at[s] = nom_len[s];
            done_at[s]  = nom_len[s];
        end
        sp_en = 1'b0; sp_s = 0; sp_b = 0; sp_r = 0; sp_d = 0;
        spur_en = 1'b0;
    endtask

    task automatic exp_nominal();
        exp_q.delete();
        for (int b = 0; b < 4; b++)
            for (int s = 0; s < 3; s++)
                exp_q.push_back(b * 1000 + s * 100 + nom_len[s]);
    endtask

    task automatic check_log(input string tag);
        int n;
        check({tag, "_len"}, log_q.size(), exp_q.size());
        n = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            check({tag, "_entry"}, log_q[i], exp_q[i]);
    endtask

    task automatic pulse_start();
        @(negedge ap_clk);
        bus.ap_start = 1'b1;
        @(negedge ap_clk);
        bus.ap_start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge ap_clk);
            if (bus.ap_done === 1'b1) seen = 1'b1;
        end
        check({tag, "_done_in_budget"}, seen, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: observed no finish, expected finish before 200000");
        $fatal(1);
    end

    initial begin
        bit found;
        ap_rst_n = 1'b0;
        bus.ap_start = 1'b0;
        set_nominal();
        #23;
        check("rst_idle",   bus.ap_idle, 1);
        check("rst_done",   bus.ap_done, 0);
        check("rst_start",  bus.stage_start, 0);
        check("rst_err",    bus.err_timeout, 0);
        check("rst_cycles", bus.cycle_count, 0);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;

        // Nominal: latencies 5,7,3 -> 4*(6+8+4)+1 = 73.
        log_q.delete(); done_cnt = 0; rdy_mis = 0;
        pulse_start();
        wait_done("nom", 300);
        @(negedge ap_clk);
        check("nom_idle",   bus.ap_idle, 1);
        check("nom_cycles", bus.cycle_count, 73);
        check("nom_err",    bus.err_timeout, 0);
        check("nom_stage",  bus.stage_idx, 0);
        check("nom_batch",  bus.batch_idx, 3);
        check("nom_dones",  done_cnt, 1);
        check("nom_rdy_eq_done", rdy_mis, 0);
        exp_nominal();
        check_log("nom_log");

        // Split handshake on stage 1 batch 0: 2 START + 4 WAIT + NEXT = 7
        // cycles instead of 8; spurious done[0] during WAIT must be ignored.
        set_nominal();
        sp_en = 1'b1; sp_s = 1; sp_b = 0; sp_r = 2; sp_d = 6; spur_en = 1'b1;
        log_q.delete();
        pulse_start();
        wait_done("split", 300);
        @(negedge ap_clk);
        check("split_cycles", bus.cycle_count, 72);
        check("split_err",    bus.err_timeout, 0);
        exp_nominal();
        exp_q[1] = 102;
        check_log("split_log");

        // Timeout: stage 2 batch 1 never answers -> 18+6+8+16+1 = 49.
        set_nominal();
        sp_en = 1'b1; sp_s = 2; sp_b = 1; sp_r = 0; sp_d = 0;
        log_q.delete(); done_cnt = 0;
        pulse_start();
        wait_done("tmo", 300);
        check("tmo_err_at_done", bus.err_timeout, 1);
        @(negedge ap_clk);
        check("tmo_idle",   bus.ap_idle, 1);
        check("tmo_cycles", bus.cycle_count, 49);
        check("tmo_sticky", bus.err_timeout, 1);
        check("tmo_stage",  bus.stage_idx, 2);
        check("tmo_batch",  bus.batch_idx, 1);
        check("tmo_dones",  done_cnt, 1);
        exp_q.delete();
        exp_q.push_back(5); exp_q.push_back(107); exp_q.push_back(203);
        exp_q.push_back(1005); exp_q.push_back(1107); exp_q.push_back(1216);
        check_log("tmo_log");
        set_nominal();
        pulse_start();
        check("tmo_err_cleared", bus.err_timeout, 0);
        check("tmo_cycles_cleared", bus.cycle_count, 0);
        wait_done("tmo_rerun", 300);
        @(negedge ap_clk);
        check("tmo_rerun_cycles", bus.cycle_count, 73);
        check("tmo_rerun_err",    bus.err_timeout, 0);

        // Done on watchdog cycle 15 of 16: 1 START + 15 WAIT + NEXT -> 84.
        set_nominal();
        sp_en = 1'b1; sp_s = 0; sp_b = 0; sp_r = 1; sp_d = 16;
        log_q.delete();
        pulse_start();
        wait_done("edge", 300);
        @(negedge ap_clk);
        check("edge_err",    bus.err_timeout, 0);
        check("edge_cycles", bus.cycle_count, 84);
        check("edge_batch",  bus.batch_idx, 3);

        // Asynchronous reset during stage 1 WAIT.
        set_nominal();
        sp_en = 1'b1; sp_s = 1; sp_b = 0; sp_r = 2; sp_d = 0;
        done_cnt = 0;
        pulse_start();
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            if (bus.stage_start[1]) found = 1'b1;
            else @(negedge ap_clk);
        end
        check("rst_mid_reached_stage1", found, 1);
        repeat (4) @(negedge ap_clk);
        #3 ap_rst_n = 1'b0;
        #1;
        check("rst_mid_idle",   bus.ap_idle, 1);
        check("rst_mid_start",  bus.stage_start, 0);
        check("rst_mid_done",   bus.ap_done, 0);
        check("rst_mid_stage",  bus.stage_idx, 0);
        check("rst_mid_batch",  bus.batch_idx, 0);
        check("rst_mid_cycles", bus.cycle_count, 0);
        repeat (3) @(negedge ap_clk);
        ap_rst_n = 1'b1;
        check("rst_mid_no_done", done_cnt, 0);
        set_nominal();
        log_q.delete();
        pulse_start();
        wait_done("rst_rerun", 300);
        @(negedge ap_clk);
        check("rst_rerun_cycles", bus.cycle_count, 73);
        exp_nominal();
        check_log("rst_rerun_log");

        // Back-to-back with ap_start held through DONE: one IDLE cycle between.
        done_cnt = 0;
        @(negedge ap_clk);
        bus.ap_start = 1'b1;
        wait_done("b2b_first", 300);
        @(negedge ap_clk);
        check("b2b_gap_idle", bus.ap_idle, 1);
        log_q.delete();
        @(negedge ap_clk);
        check("b2b_restart_idle",  bus.ap_idle, 0);
        check("b2b_restart_start", bus.stage_start, 1);
        bus.ap_start = 1'b0;
        wait_done("b2b_second", 300);
        @(negedge ap_clk);
        check("b2b_cycles", bus.cycle_count, 73);
        check("b2b_dones",  done_cnt, 2);
        check("b2b_rdy_eq_done", rdy_mis, 0);
        exp_nominal();
        check_log("b2b_log");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
